// File: rtl/elevator_scheduler_if.sv
// Call/hold inputs and car status outputs of the elevator scheduler.
// The scheduler uses the slave modport; the call source or bench uses the master modport.
interface elevator_scheduler_if #(
  parameter int NUM_FLOORS = 4
);
  localparam int FW = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;

  logic [NUM_FLOORS-1:0] call_req;
  logic                  hold;
  logic [FW-1:0]         cur_floor;
  logic                  moving;
  logic                  dir_up;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] pending;

  modport master (
    output call_req, hold,
    input  cur_floor, moving, dir_up, door_open, pending
  );

  modport slave (
    input  call_req, hold,
    output cur_floor, moving, dir_up, door_open, pending
  );
endinterface

// File: rtl/elevator_scheduler.sv
// SCAN elevator scheduler: latches floor calls, moves the car one floor per
// TRAVEL_CYCLES, and runs a timed door that can be held open or re-called.
module elevator_scheduler #(
  parameter int NUM_FLOORS    = 4,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  elevator_scheduler_if.slave     bus
);
  localparam int FW   = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
  localparam logic [FW-1:0] TOP_FLOOR   = FW'(NUM_FLOORS - 1);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  state_t                r_state,   w_state_nx;
  logic [FW-1:0]         r_floor,   w_floor_nx;
  logic                  r_dir_up,  w_dir_up_nx;
  logic [NUM_FLOORS-1:0] r_pending, w_pending_nx;
  logic [TW-1:0]         r_timer,   w_timer_nx;

  logic [NUM_FLOORS-1:0] w_req;
  logic                  w_above;
  logic                  w_below;
  logic [FW-1:0]         w_step_floor;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_floor   <= '0;
      r_dir_up  <= 1'b1;
      r_pending <= '0;
      r_timer   <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_floor   <= w_floor_nx;
      r_dir_up  <= w_dir_up_nx;
      r_pending <= w_pending_nx;
      r_timer   <= w_timer_nx;
    end
  end

  always_comb begin
    w_req   = r_pending | bus.call_req;
    w_above = 1'b0;
    w_below = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (w_req[i] && (i > 32'(r_floor))) w_above = 1'b1;
      if (w_req[i] && (i < 32'(r_floor))) w_below = 1'b1;
    end
    // Saturate at the shaft ends; a call ahead always exists in MOVE so this never bites.
    w_step_floor = r_floor;
    if (r_dir_up && (r_floor != TOP_FLOOR)) w_step_floor = r_floor + FW'(1);
    else if (!r_dir_up && (r_floor != '0))  w_step_floor = r_floor - FW'(1);
  end

  always_comb begin
    w_state_nx   = r_state;
    w_floor_nx   = r_floor;
    w_dir_up_nx  = r_dir_up;
    w_pending_nx = w_req;
    w_timer_nx   = r_timer;
    unique case (r_state)
      IDLE: begin
        if (w_req[r_floor]) begin
          w_state_nx            = DOOR;
          w_pending_nx[r_floor] = 1'b0;
          w_timer_nx            = DOOR_LOAD;
        end else if (r_dir_up && w_above) begin
          w_state_nx = MOVE;
          w_timer_nx = TRAVEL_LOAD;
        end else if (w_below) begin
          w_state_nx  = MOVE;
          w_dir_up_nx = 1'b0;
          w_timer_nx  = TRAVEL_LOAD;
        end else if (w_above) begin
          w_state_nx  = MOVE;
          w_dir_up_nx = 1'b1;
          w_timer_nx  = TRAVEL_LOAD;
        end
      end
      MOVE: begin
        if (r_timer != '0) begin
          w_timer_nx = r_timer - TW'(1);
        end else begin
          w_floor_nx = w_step_floor;
          if (w_req[w_step_floor]) begin
            w_state_nx                 = DOOR;
            w_pending_nx[w_step_floor] = 1'b0;
            w_timer_nx                 = DOOR_LOAD;
          end else begin
            w_timer_nx = TRAVEL_LOAD;
          end
        end
      end
      DOOR: begin
        w_pending_nx[r_floor] = 1'b0;
        if (w_req[r_floor] || bus.hold) w_timer_nx = DOOR_LOAD;
        else if (r_timer != '0)         w_timer_nx = r_timer - TW'(1);
        else                            w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.cur_floor = r_floor;
    bus.dir_up    = r_dir_up;
    bus.pending   = r_pending;
    bus.moving    = (r_state == MOVE);
    bus.door_open = (r_state == DOOR);
  end
endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler with hand-computed expectations
// (NUM_FLOORS=4, TRAVEL_CYCLES=8, DOOR_CYCLES=4).
module tb_elevator_scheduler;
  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  elevator_scheduler_if #(.NUM_FLOORS(4)) u_if ();

  elevator_scheduler #(
    .NUM_FLOORS   (4),
    .TRAVEL_CYCLES(8),
    .DOOR_CYCLES  (4)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_call(input logic [3:0] v);
    u_if.call_req = v;
    step(1);
    u_if.call_req = '0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset = 1'b1;
    u_if.call_req = '0;
    u_if.hold     = 1'b0;
    step(2);
    check("rst_floor", 32'(u_if.cur_floor), 0);
    check("rst_moving", 32'(u_if.moving), 0);
    check("rst_dir", 32'(u_if.dir_up), 1);
    check("rst_door", 32'(u_if.door_open), 0);
    check("rst_pend", 32'(u_if.pending), 0);
    reset = 1'b0;
    step(1);

    // Single call to floor 2 from reset
    pulse_call(4'b0100);
    check("a_mv0", 32'(u_if.moving), 1);
    check("a_pend", 32'(u_if.pending), 32'b0100);
    step(7);
    check("a_fl0_t7", 32'(u_if.cur_floor), 0);
    step(1);
    check("a_fl1_t8", 32'(u_if.cur_floor), 1);
    check("a_mv_t8", 32'(u_if.moving), 1);
    step(7);
    check("a_mv_t15", 32'(u_if.moving), 1);
    step(1);
    check("a_fl2_t16", 32'(u_if.cur_floor), 2);
    check("a_door_t16", 32'(u_if.door_open), 1);
    check("a_mv_t16", 32'(u_if.moving), 0);
    check("a_pend_t16", 32'(u_if.pending), 0);
    step(3);
    check("a_door_t19", 32'(u_if.door_open), 1);
    step(1);
    check("a_door_t20", 32'(u_if.door_open), 0);
    check("a_mv_t20", 32'(u_if.moving), 0);

    // Hold keeps the door open at floor 2
    pulse_call(4'b0100);
    check("b_door", 32'(u_if.door_open), 1);
    check("b_mv", 32'(u_if.moving), 0);
    u_if.hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("b_hold_door", 32'(u_if.door_open), 1);
    end
    u_if.hold = 1'b0;
    step(3);
    check("b_tail_door", 32'(u_if.door_open), 1);
    step(1);
    check("b_close", 32'(u_if.door_open), 0);

    // Re-call of the open floor restarts the door count
    pulse_call(4'b0100);
    step(2);
    pulse_call(4'b0100);
    check("c_door", 32'(u_if.door_open), 1);
    check("c_pend", 32'(u_if.pending), 0);
    step(3);
    check("c_tail_door", 32'(u_if.door_open), 1);
    step(1);
    check("c_close", 32'(u_if.door_open), 0);

    // Down to floor 0
    pulse_call(4'b0001);
    check("d_mv", 32'(u_if.moving), 1);
    check("d_dir", 32'(u_if.dir_up), 0);
    step(16);
    check("d_floor", 32'(u_if.cur_floor), 0);
    check("d_door", 32'(u_if.door_open), 1);
    step(4);
    check("d_close", 32'(u_if.door_open), 0);

    // Call at the current floor while idle at 0
    pulse_call(4'b0001);
    check("e_door", 32'(u_if.door_open), 1);
    check("e_mv", 32'(u_if.moving), 0);
    step(3);
    check("e_door3", 32'(u_if.door_open), 1);
    check("e_mv3", 32'(u_if.moving), 0);
    step(1);
    check("e_close", 32'(u_if.door_open), 0);

    // Passing floor: 0 -> 3 with floor 2 called between 1 and 2
    pulse_call(4'b1000);
    check("f_mv", 32'(u_if.moving), 1);
    check("f_dir", 32'(u_if.dir_up), 1);
    step(8);
    check("f_fl1", 32'(u_if.cur_floor), 1);
    step(2);
    pulse_call(4'b0100);
    check("f_pend", 32'(u_if.pending), 32'b1100);
    step(5);
    check("f_fl2", 32'(u_if.cur_floor), 2);
    check("f_door2", 32'(u_if.door_open), 1);
    check("f_pend2", 32'(u_if.pending), 32'b1000);
    step(4);
    check("f_idle_door", 32'(u_if.door_open), 0);
    check("f_idle_mv", 32'(u_if.moving), 0);
    step(1);
    check("f_resume", 32'(u_if.moving), 1);
    step(8);
    check("f_fl3", 32'(u_if.cur_floor), 3);
    check("f_door3", 32'(u_if.door_open), 1);
    check("f_pend3", 32'(u_if.pending), 0);
    step(4);

    // Back to floor 0 to set up the SCAN case
    pulse_call(4'b0001);
    check("g_down_dir", 32'(u_if.dir_up), 0);
    step(24);
    check("g_at0", 32'(u_if.cur_floor), 0);
    check("g_door0", 32'(u_if.door_open), 1);
    step(4);

    // SCAN: moving up past floor 1, floors 0 and 3 called together
    pulse_call(4'b1000);
    step(8);
    check("g_fl1", 32'(u_if.cur_floor), 1);
    pulse_call(4'b1001);
    check("g_pend", 32'(u_if.pending), 32'b1001);
    check("g_dir_up", 32'(u_if.dir_up), 1);
    step(15);
    check("g_fl3", 32'(u_if.cur_floor), 3);
    check("g_door3", 32'(u_if.door_open), 1);
    check("g_pend3", 32'(u_if.pending), 32'b0001);
    step(4);
    check("g_idle_mv", 32'(u_if.moving), 0);
    check("g_idle_dir", 32'(u_if.dir_up), 1);
    step(1);
    check("g_rev_mv", 32'(u_if.moving), 1);
    check("g_rev_dir", 32'(u_if.dir_up), 0);
    step(24);
    check("g_fl0", 32'(u_if.cur_floor), 0);
    check("g_door0b", 32'(u_if.door_open), 1);
    check("g_pend0", 32'(u_if.pending), 0);
    step(4);

    // Reset mid-travel discards everything
    pulse_call(4'b1000);
    step(9);
    check("h_pre_floor", 32'(u_if.cur_floor), 1);
    check("h_pre_mv", 32'(u_if.moving), 1);
    check("h_pre_pend", 32'(u_if.pending), 32'b1000);
    reset = 1'b1;
    step(1);
    check("h_rst_floor", 32'(u_if.cur_floor), 0);
    check("h_rst_mv", 32'(u_if.moving), 0);
    check("h_rst_dir", 32'(u_if.dir_up), 1);
    check("h_rst_door", 32'(u_if.door_open), 0);
    check("h_rst_pend", 32'(u_if.pending), 0);
    reset = 1'b0;
    step(2);
    check("h_post_mv", 32'(u_if.moving), 0);
    check("h_post_pend", 32'(u_if.pending), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Multi-floor elevator controller that latches floor calls, schedules car travel with a SCAN policy (keep the current direction while calls remain ahead), models floor-to-floor travel time, and sequences a timed door with a hold input. It is the sequencing layer above the single-floor elevator FSM. It owns the car position and direction, and decides which floor is served next.

## Interface
- NUM_FLOORS, 4, number of floors (≥2); floors numbered 0..NUM_FLOORS-1
- TRAVEL_CYCLES, 8, clock cycles to move one floor (≥1)
- DOOR_CYCLES, 4, clock cycles the door stays open without hold (≥1)
- FW, $clog2(NUM_FLOORS), floor index width (derived localparam)

- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; one clock; sampled on rising edge of clk
- call_req  in  NUM_FLOORS  per-floor call; bit i high for ≥1 cycle requests floor i; combined cab and hall calls
- hold  in  1  door hold; while high in DOOR state, door timer reloads
- cur_floor  out  FW  current car floor
- moving  out  1  high in MOVE state
- dir_up  out  1  current/last travel direction (1 = up)
- door_open  out  1  high in DOOR state
- pending  out  NUM_FLOORS  latched, not-yet-served calls

## Operation
- States: IDLE, MOVE, DOOR. Registers: state, cur_floor, dir_up, pending, timer.
- Reset values: state=IDLE, cur_floor=0, dir_up=1, pending=0, timer=0, moving=0, door_open=0.
- Effective requests each cycle: req = pending | call_req. Each edge, pending <= req with the served bit cleared (see below).
- above = any req bit at index > cur_floor; below = any req bit at index < cur_floor.
- IDLE:
  - req[cur_floor] set -> DOOR, clear bit, timer <= DOOR_CYCLES-1.
  - else if dir_up and above -> MOVE up.
  - else if below -> MOVE down (dir_up <= 0).
  - else if above -> MOVE up (dir_up <= 1).
  - else stay IDLE.
  - On MOVE entry, timer <= TRAVEL_CYCLES-1.
- MOVE:
  - If timer≠0, timer decrements.
  - If timer=0, cur_floor steps ±1 per dir_up. Then:
    - if req[new floor] -> DOOR, clear bit, timer <= DOOR_CYCLES-1;
    - else stay MOVE, timer <= TRAVEL_CYCLES-1.
  - A call ahead always exists in MOVE: calls are never cancelled, and MOVE is entered only toward a call. The car therefore never reverses mid-MOVE.
  - cur_floor never leaves 0..NUM_FLOORS-1.
- DOOR:
  - A call for cur_floor, or hold high, reloads timer to DOOR_CYCLES-1. The cur_floor call bit is not latched into pending.
  - Otherwise, if timer≠0, timer decrements.
  - If timer=0 with hold low and no cur_floor call -> IDLE.
- Calls for other floors are latched in every state. Simultaneous calls are all latched.
- SCAN: after DOOR -> IDLE, dir_up is retained, so calls ahead are served before reversal.
- Reset asserted in any state, including mid-travel or door open, returns all registers to reset values on that edge. Pending calls are discarded.

## Timing
- Outputs are registered or decoded from registered state only. There is no combinational path from call_req or hold to outputs.
- Call to a different floor sampled at IDLE edge t: moving=1 from edge t.
- Travel is TRAVEL_CYCLES cycles per floor.
- cur_floor updates on the last MOVE edge of each floor.
- door_open rises on the same edge cur_floor reaches a called floor.
- Call at cur_floor sampled at IDLE edge t: door_open=1 from edge t for exactly DOOR_CYCLES cycles, absent hold or re-call.
- DOOR -> IDLE -> next MOVE/DOOR costs one IDLE cycle.
- pending bit for a floor clears on the same edge door_open rises there.

## Test plan
- Reset mid-MOVE (cur_floor=1, moving=1, pending=4'b1000): on the reset edge, all outputs return to 0, except dir_up=1.
- From reset, pulse call_req=4'b0100 one cycle, with TRAVEL_CYCLES=8 and DOOR_CYCLES=4:
  - moving=1 for 16 cycles; cur_floor=1 after 8, 2 after 16;
  - door_open=1 for 4 cycles, then IDLE;
  - pending[2] clears at door open.
- SCAN ordering, car at floor 1 moving up:
  - at the same cycle, call floors 0 and 3;
  - car serves 3 first (door opens at 3), then reverses;
  - dir_up=0 and car opens at 0.
- Call at current floor while IDLE at floor 0:
  - door_open=1 on the next edge, for 4 cycles;
  - moving stays 0.
- Door extension, in DOOR at floor 2:
  - hold high for 6 cycles keeps door_open=1 throughout, plus 4 cycles after hold falls;
  - a call_req[2] pulse while open likewise restarts the 4-cycle count.
- Passing floor: moving 0 -> 3 with call to floor 2 asserted while between floors 1 and 2:
  - car stops at 2 (door 4 cycles), then continues up to 3.
